// File: rtl/parity_serial_receiver.sv
// Serial byte receiver: start, 8 data bits LSB first, optional parity, stop; mid-bit sampling.
// Build option: define RX_PARITY_EN to include the parity bit (11-bit frame), otherwise 10-bit frame.
module parity_serial_receiver #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ODD_PARITY   = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LP_HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LP_FULL_M1 = CW'(CLKS_PER_BIT - 1);

`ifdef RX_PARITY_EN
    localparam logic LP_ODD = (ODD_PARITY != 0);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3,
        S_STOP = 3'd4, S_DONE = 3'd5, S_WAIT_HIGH = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
        S_STOP = 3'd4, S_DONE = 3'd5, S_WAIT_HIGH = 3'd6
    } state_t;
`endif

    state_t          r_state;
    state_t          w_state_next;
    logic            r_sync1;
    logic            r_rs;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic            r_pbit_err;
    logic [7:0]      r_rx_data;
    logic            r_rx_valid;
    logic            r_parity_err;
    logic            r_frame_err;
    logic            r_busy;
    logic            w_half_tick;
    logic            w_full_tick;

    assign w_half_tick = (r_cnt == LP_HALF_M1);
    assign w_full_tick = (r_cnt == LP_FULL_M1);

    // Two-flop synchronizer for the asynchronous line, idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_rs    <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_rs    <= r_sync1;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!r_rs) w_state_next = S_START;
                else       w_state_next = r_state;
            end
            S_START: begin
                if (w_half_tick) w_state_next = r_rs ? S_IDLE : S_DATA;
                else             w_state_next = r_state;
            end
            S_DATA: begin
`ifdef RX_PARITY_EN
                if (w_full_tick && (r_idx == 3'd7)) w_state_next = S_PARITY;
`else
                if (w_full_tick && (r_idx == 3'd7)) w_state_next = S_STOP;
`endif
                else                                w_state_next = r_state;
            end
`ifdef RX_PARITY_EN
            S_PARITY: begin
                if (w_full_tick) w_state_next = S_STOP;
                else             w_state_next = r_state;
            end
`endif
            S_STOP: begin
                if (w_full_tick) w_state_next = S_DONE;
                else             w_state_next = r_state;
            end
            // A line still low after the frame must rise before a new start is accepted
            S_DONE: begin
                if (r_rs) w_state_next = S_IDLE;
                else      w_state_next = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (r_rs) w_state_next = S_IDLE;
                else      w_state_next = r_state;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bit-period counter: half period in START, full periods afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_START:          r_cnt <= w_half_tick ? '0 : r_cnt + CW'(1);
                S_DATA, S_STOP:   r_cnt <= w_full_tick ? '0 : r_cnt + CW'(1);
`ifdef RX_PARITY_EN
                S_PARITY:         r_cnt <= w_full_tick ? '0 : r_cnt + CW'(1);
`endif
                default:          r_cnt <= '0;
            endcase
        end
    end

    // Datapath: shift in data, evaluate parity, publish result on the stop sample
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx        <= 3'd0;
            r_shift      <= 8'h00;
            r_pbit_err   <= 1'b0;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_busy     <= (w_state_next != S_IDLE);
            case (r_state)
                S_IDLE: r_idx <= 3'd0;
                S_DATA: begin
                    if (w_full_tick) begin
                        r_shift <= {r_rs, r_shift[7:1]};
                        r_idx   <= r_idx + 3'd1;
                    end
                end
`ifdef RX_PARITY_EN
                S_PARITY: begin
                    if (w_full_tick) r_pbit_err <= (((^r_shift) ^ r_rs) != LP_ODD);
                end
`endif
                // Outputs become visible in the DONE cycle, one cycle after the stop sample
                S_STOP: begin
                    if (w_full_tick) begin
                        r_rx_data    <= r_shift;
                        r_parity_err <= r_pbit_err;
                        r_frame_err  <= ~r_rs;
                        r_rx_valid   <= 1'b1;
                    end
                end
                default: r_idx <= r_idx;
            endcase
        end
    end

    assign o_rx_data    = r_rx_data;
    assign o_rx_valid   = r_rx_valid;
    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_parity_serial_receiver.sv
// Scoreboard bench for parity_serial_receiver: even- and odd-parity instances share one serial line.
`timescale 1ns/1ps
module tb_parity_serial_receiver;

    localparam int C = 16;
    localparam int H = C / 2;
`ifdef RX_PARITY_EN
    localparam int NB  = 11;
    localparam bit PEN = 1'b1;
`else
    localparam int NB  = 10;
    localparam bit PEN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] data_e, data_o;
    logic       v_e, v_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

    parity_serial_receiver #(.CLKS_PER_BIT(C), .ODD_PARITY(0)) u_even (
        .clk(clk), .reset(reset), .i_rx(rx), .o_rx_data(data_e), .o_rx_valid(v_e),
        .o_parity_err(pe_e), .o_frame_err(fe_e), .o_busy(busy_e));

    parity_serial_receiver #(.CLKS_PER_BIT(C), .ODD_PARITY(1)) u_odd (
        .clk(clk), .reset(reset), .i_rx(rx), .o_rx_data(data_o), .o_rx_valid(v_o),
        .o_parity_err(pe_o), .o_frame_err(fe_o), .o_busy(busy_o));

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        longint     at;
    } exp_t;

    exp_t q_even[$];
    exp_t q_odd[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   busy_seen = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: parity from ones count, valid cycle from frame length.
    // Line driven after edge e0 -> rs low from edge e0+2 (t0), valid at t0 + H + (NB-1)*C + 1.
    function automatic exp_t model(input logic [7:0] d, input logic pbit, input logic stop,
                                   input bit odd, input longint e0);
        exp_t m;
        int   ones;
        ones   = $countones(d) + int'(pbit);
        m.data = d;
        m.perr = PEN ? (((ones % 2) == 1) != odd) : 1'b0;
        m.ferr = !stop;
        m.at   = e0 + 2 + H + (NB - 1) * C + 1;
        return m;
    endfunction

    task automatic on_valid(input bit which, input logic [7:0] d, input logic pe, input logic fe);
        exp_t  e;
        string tag;
        tag = which ? "odd" : "even";
        if ((which ? q_odd.size() : q_even.size()) == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_unexpected_valid: got rx_valid data %0h, required no pulse (cycle %0d)",
                     tag, d, cyc);
        end else begin
            if (which) e = q_odd.pop_front();
            else       e = q_even.pop_front();
            check({tag, "_data"},  64'(d),  64'(e.data));
            check({tag, "_perr"},  64'(pe), 64'(e.perr));
            check({tag, "_ferr"},  64'(fe), 64'(e.ferr));
            check({tag, "_cycle"}, 64'(cyc), 64'(e.at));
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (v_e) on_valid(1'b0, data_e, pe_e, fe_e);
            if (v_o) on_valid(1'b1, data_o, pe_o, fe_o);
            if (busy_e) busy_seen = 1'b1;
        end
    end

    // Entered and left at #1 after a rising edge
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop, input int gap);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (PEN) bits.push_back(pbit);
        bits.push_back(stop);
        q_even.push_back(model(d, pbit, stop, 1'b0, cyc));
        q_odd.push_back(model(d, pbit, stop, 1'b1, cyc));
        foreach (bits[i]) begin
            rx = bits[i];
            repeat (C) @(posedge clk);
            #1;
        end
        if (gap > 0) begin
            rx = 1'b1;
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_even_data"},  64'(data_e), 64'h0);
        check({tag, "_even_valid"}, 64'(v_e),    64'h0);
        check({tag, "_even_perr"},  64'(pe_e),   64'h0);
        check({tag, "_even_ferr"},  64'(fe_e),   64'h0);
        check({tag, "_even_busy"},  64'(busy_e), 64'h0);
        check({tag, "_odd_data"},   64'(data_o), 64'h0);
        check({tag, "_odd_perr"},   64'(pe_o),   64'h0);
        check({tag, "_odd_ferr"},   64'(fe_o),   64'h0);
        check({tag, "_odd_busy"},   64'(busy_o), 64'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic       p, s;
        int         g;

        reset = 1'b1;
        rx    = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send_frame(8'hA5, 1'b0, 1'b1, 20);
        send_frame(8'h01, 1'b0, 1'b1, 20);

        // Stop bit low and line stuck low: one frame with frame_err, then no repeats
        send_frame(8'h3C, 1'b0, 1'b0, 0);
        repeat (40) @(posedge clk);
        #1;
        check("stuck_low_busy", 64'(busy_e), 64'h1);
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("after_rise_busy", 64'(busy_e), 64'h0);

        // Short glitch on idle line
        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (3 * C) @(posedge clk);
        #1;
        check("glitch_busy_pulsed", 64'(busy_seen), 64'h1);
        check("glitch_busy_idle",   64'(busy_e),    64'h0);

        send_frame(8'h55, 1'b0, 1'b1, 0);
        send_frame(8'hAA, 1'b0, 1'b1, 20);

        // Reset in the middle of data bit 4
        d  = 8'hF0;
        rx = 1'b0;
        repeat (C) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (C) @(posedge clk);
            #1;
        end
        rx = d[4];
        repeat (H) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("midreset");
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3 * C) @(posedge clk);
        #1;

        send_frame(8'h7E, 1'b0, 1'b1, 20);

        repeat (24) begin
            d = 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 7) != 0);
            g = s ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 20));
            send_frame(d, p, s, g);
        end

        rx = 1'b1;
        for (int i = 0; i < 1000 && (q_even.size() != 0 || q_odd.size() != 0); i++) @(posedge clk);
        repeat (2 * C) @(posedge clk);
        #1;
        check("drain_even", 64'(q_even.size()), 64'h0);
        check("drain_odd",  64'(q_odd.size()),  64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/parity_serial_receiver.md
# parity_serial_receiver

Serial receiver that sits directly downstream of the parity serial transmitter. Recovers bytes from a single-wire asynchronous line framed as start bit, 8 data bits LSB first, parity bit, stop bit. Samples each bit at mid-period using a bit-period counter. Presents each recovered byte with one-cycle valid and parity/framing error flags to the consuming logic.

## Interface
- CLKS_PER_BIT, default 16: clk cycles per serial bit; even, ≥4.
- ODD_PARITY, default 0: 0 = even parity (data ones + parity bit is even), 1 = odd parity.
- clk  input  1  system clock, rising edge.
- reset  input  1  reset, synchronous, active-high.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rx_data  output  8  last received byte, held until the next frame completes.
- rx_valid  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  parity mismatch on last frame; valid with rx_valid, held.
- frame_err  output  1  stop bit sampled low on last frame; valid with rx_valid, held.
- busy  output  1  high from start-bit detection until return to IDLE.

## Operation
- rx passes through a 2-flop synchronizer (rs) reset to 1. All decisions use rs.
- FSM states: IDLE, START, DATA, PARITY, STOP, DONE, WAIT_HIGH.
- IDLE: rs=0 -> START, bit counter cleared, busy=1.
- START: after CLKS_PER_BIT/2 cycles, sample rs. 0 -> DATA. 1 -> IDLE as glitch, busy=0, no rx_valid.
- DATA: sample every CLKS_PER_BIT cycles. Shift the sampled bit into the MSB of an 8-bit shift register so bit 0 lands in the LSB. After the 8th sample -> PARITY.
- PARITY: sample one bit. parity_err_next = (^data ^ pbit) != ODD_PARITY.
- STOP: sample one bit. frame_err_next = ~sample. Go to DONE.
- DONE, one cycle: load rx_data, parity_err, frame_err; rx_valid=1. Then go to IDLE if rs=1, else WAIT_HIGH.
- WAIT_HIGH: stay until rs=1, then IDLE. A stuck-low line never creates repeated frames.
- Data and parity are reported on a framing error; the consumer decides whether to discard them.
- Bit counter width: ceil(log2(CLKS_PER_BIT)). Wraps to 0 at CLKS_PER_BIT-1. Index counter is 3 bits.

## Timing
- Reset values: rx_data=0x00, rx_valid=0, parity_err=0, frame_err=0, busy=0, FSM=IDLE, synchronizer=1.
- Let t0 = first cycle rs=0 in IDLE. Samples occur at t0 + CLKS_PER_BIT/2 + k·CLKS_PER_BIT for k=0..10 (start, d0..d7, parity, stop).
- rx_valid is high exactly one cycle, the cycle after the stop sample. Its cycle is t0 + CLKS_PER_BIT/2 + 10·CLKS_PER_BIT + 1.
- Input-to-rs latency is 2 clk.
- Back-to-back frames: a start edge seen in the cycle after DONE is accepted with no lost bits.
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values. No rx_valid is produced for the partial frame.
- There is no backpressure. A consumer that misses rx_valid loses the byte.

## Configuration
- RX_PARITY_EN defined: the PARITY state is present and checked as above. The frame is 11 bits.
- RX_PARITY_EN undefined:
  - The PARITY state is removed; STOP follows DATA directly.
  - The frame is 10 bits and rx_valid occurs CLKS_PER_BIT cycles earlier.
  - parity_err is tied to 0.
  - ODD_PARITY is ignored.

## Test plan
All scenarios use CLKS_PER_BIT=16, ODD_PARITY=0, RX_PARITY_EN defined unless noted.
- Send 0xA5 with parity 0 and stop 1 -> one rx_valid pulse, rx_data=0xA5, parity_err=0, frame_err=0, pulse at t0+169.
- Send 0x01 with parity 0 -> rx_valid, rx_data=0x01, parity_err=1. ODD_PARITY=1 with the same stimulus -> parity_err=0.
- Send 0x3C with parity 0, stop bit 0, line held low for 40 cycles -> rx_valid with frame_err=1 and rx_data=0x3C. FSM stays in WAIT_HIGH with no further rx_valid until the line rises.
- Drive a 4-cycle low glitch on the idle line -> busy pulses, no rx_valid, back in IDLE.
- Send 0x55 then 0xAA back-to-back with no idle gap -> two rx_valid pulses 176 cycles apart carrying 0x55 and 0xAA, no errors.
- Assert reset at data bit 4 of a frame -> all outputs 0 next cycle, no rx_valid. A following 0x7E frame is received correctly. With RX_PARITY_EN undefined, 0x7E sent with no parity bit gives rx_valid at t0+153.
